// File: rtl/comb_sweep_ctrl.sv
// comb_sweep_ctrl: exhaustive truth-table sweep sequencer for a small
// combinational block. Drives each input vector, waits SETTLE_CYCLES,
// samples y_in into obs_tt and counts mismatches against exp_tt.
// Optional build macro SWEEP_GRAY_EN: step through vectors in Gray order
// instead of binary order (cycle timing is unchanged).
module comb_sweep_ctrl #(
    parameter int N_IN          = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   exp_tt,
    input  logic                 y_in,
    output logic [N_IN-1:0]      vec,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   obs_tt,
    output logic [N_IN:0]        mismatch_cnt,
    output logic                 pass
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t          state;
    logic [3:0]      settle_cnt;
    logic [N_IN-1:0] idx;
    logic            miss;
    logic [N_IN:0]   cnt_next;

    // Step index to driven vector; tables stay indexed by the vector value.
    function automatic logic [N_IN-1:0] vector_of(input logic [N_IN-1:0] i);
`ifdef SWEEP_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    // Compare the live block output against the expected bit for the held vector.
    always_comb begin
        miss     = y_in ^ exp_tt[vec];
        cnt_next = mismatch_cnt + {{N_IN{1'b0}}, miss};
    end

    // Sweep sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            vec          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            obs_tt       <= '0;
            mismatch_cnt <= '0;
            settle_cnt   <= '0;
            idx          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        state        <= SETTLE;
                        idx          <= '0;
                        vec          <= vector_of('0);
                        busy         <= 1'b1;
                        obs_tt       <= '0;
                        mismatch_cnt <= '0;
                        pass         <= 1'b0;
                        settle_cnt   <= '0;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        vec        <= '0;
                        pass       <= 1'b0;
                        settle_cnt <= '0;
                        idx        <= '0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        vec        <= '0;
                        pass       <= 1'b0;
                        settle_cnt <= '0;
                        idx        <= '0;
                    end else begin
                        obs_tt[vec]  <= y_in;
                        mismatch_cnt <= cnt_next;
                        if (idx != '1) begin
                            idx   <= idx + 1'b1;
                            vec   <= vector_of(idx + 1'b1);
                            state <= SETTLE;
                        end else begin
                            // pass uses the count including this final sample
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (cnt_next == '0);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Self-checking bench for comb_sweep_ctrl. The block under control is a
// 16-entry truth table (blk_tt) looked up by vec; expected results come from
// table constants and a popcount model of blk_tt ^ exp_tt.
module tb_comb_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] exp_tt;
    logic        y_in;
    logic [3:0]  vec;
    logic        busy;
    logic        done;
    logic [15:0] obs_tt;
    logic [4:0]  mismatch_cnt;
    logic        pass;

    logic [15:0] blk_tt;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [15:0] blk;
        logic [15:0] expt;
        logic [15:0] obs;
        int          cnt;
        logic        pss;
    } vec_t;

    vec_t tbl [6];

    comb_sweep_ctrl #(.N_IN(4), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .exp_tt(exp_tt), .y_in(y_in), .vec(vec), .busy(busy), .done(done),
        .obs_tt(obs_tt), .mismatch_cnt(mismatch_cnt), .pass(pass)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // the combinational block: a lookup of its truth table
    assign y_in = blk_tt[vec];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [3:0] vec_of(input int i);
        logic [3:0] v;
        v = 4'(i);
`ifdef SWEEP_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    function automatic int pop16(input logic [15:0] x);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(x[i]);
        return n;
    endfunction

    // One sweep; abort_at / xstart_at are busy-cycle numbers (0-based) or -1.
    task automatic sweep(input logic [15:0] b, input logic [15:0] e,
                         input int abort_at, input int xstart_at);
        int ks, busy_n, seq_err, done_cyc;
        logic [15:0] mask;
        logic        pass_hold;
        blk_tt = b;
        exp_tt = e;
        @(negedge clk);
        start = 1'b1;
        ks = cyc;
        @(negedge clk);
        start = 1'b0;
        check("start_clear", {obs_tt, 11'd0, mismatch_cnt}, 32'd0);
        check("start_busy", {busy, vec}, {1'b1, vec_of(0)});
        busy_n = 0; seq_err = 0; done_cyc = -1;
        for (int t = 0; t < 200; t++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (busy) begin
                if (vec !== vec_of(busy_n / 3)) seq_err++;
                busy_n++;
            end
            if (busy_n - 1 == abort_at && abort_at >= 0) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("abort_state", {busy, done, pass, vec}, 32'd0);
                mask = '0;
                for (int i = 0; i < 16; i++)
                    if (3 * i + 2 < abort_at) mask[vec_of(i)] = 1'b1;
                done_cyc = 0;
                for (int w = 0; w < 60; w++) begin
                    if (done || busy) done_cyc++;
                    @(negedge clk);
                end
                check("abort_no_done", done_cyc, 0);
                check("abort_partial_obs", obs_tt, b & mask);
                check("abort_partial_cnt", mismatch_cnt, pop16((b ^ e) & mask));
                check("abort_seq", seq_err, 0);
                return;
            end
            start = (busy_n - 1 == xstart_at);
            @(negedge clk);
            start = 1'b0;
        end
        check("done_latency", done_cyc - ks, 49);
        check("busy_cycles", busy_n, 48);
        check("vec_sequence", seq_err, 0);
        check("obs_tt", obs_tt, b);
        check("mismatch_cnt", mismatch_cnt, pop16(b ^ e));
        check("pass", pass, pop16(b ^ e) == 0);
        pass_hold = pass;
        @(negedge clk);
        check("done_one_cycle", {done, busy, pass}, {2'b00, pass_hold});
    endtask

    initial begin
        int bad, ks;
        tbl[0] = '{16'hF000, 16'hF000, 16'hF000, 0,  1'b1};  // A&B
        tbl[1] = '{16'hFFF0, 16'hF000, 16'hFFF0, 8,  1'b0};  // A|B
        tbl[2] = '{16'h0000, 16'hFFFF, 16'h0000, 16, 1'b0};  // max count
        tbl[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 0,  1'b1};
        tbl[4] = '{16'h6996, 16'h6996, 16'h6996, 0,  1'b1};  // parity
        tbl[5] = '{16'h8000, 16'h0001, 16'h8000, 2,  1'b0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; exp_tt = '0; blk_tt = '0;
        repeat (3) @(negedge clk);
        check("reset_vals", {vec, busy, done, obs_tt, mismatch_cnt, pass}, 32'd0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({vec, busy, done, obs_tt, mismatch_cnt, pass} !== '0) bad++;
        end
        check("idle_after_reset", bad, 0);

        // table-driven full sweeps
        for (int i = 0; i < 6; i++) begin
            sweep(tbl[i].blk, tbl[i].expt, -1, -1);
            check("tbl_obs", obs_tt, tbl[i].obs);
            check("tbl_cnt", mismatch_cnt, tbl[i].cnt);
            check("tbl_pass", pass, tbl[i].pss);
        end

        // abort mid-sweep, then a clean full sweep
        sweep(16'hFFF0, 16'hF000, 19, -1);
        sweep(16'hF000, 16'hF000, -1, -1);

        // extra start while busy is ignored
        sweep(16'hFFF0, 16'hF000, -1, 10);

        // start and abort together in IDLE
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy || done) bad++;
            @(negedge clk);
        end
        check("start_abort_same", bad, 0);

        // randomized sweeps against the popcount model
        for (int r = 0; r < 8; r++)
            sweep(16'($urandom), 16'($urandom), -1, -1);

        // asynchronous reset mid-sweep
        blk_tt = 16'hFFFF; exp_tt = 16'h0000;
        @(negedge clk);
        start = 1'b1;
        ks = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < ks + 30) @(negedge clk);
        check("pre_reset_busy", {busy, (obs_tt != 0)}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("rst_mid_async", {vec, busy, done, obs_tt, mismatch_cnt, pass}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy || done) bad++;
        end
        check("rst_mid_no_done", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
